time_pulse_generator: RTL and testbench

TIME_PULSE_GENERATOR -- requirements
Module: time_pulse_generator

---
 rtl/agc_tpg_pkg.sv | 35 +++
 rtl/time_pulse_generator.sv | 94 +++++++++
 tb/tb_time_pulse_generator.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_tpg_pkg.sv
// Shared definitions for the time-pulse generator: state encoding and the
// one-hot decode of a state onto the T1..T12 pulse lines.
package agc_tpg_pkg;

    localparam int TP_COUNT = 12;

    typedef enum logic [3:0] {
        TP_ZERO = 4'd0,
        TP1     = 4'd1,
        TP2     = 4'd2,
        TP3     = 4'd3,
        TP4     = 4'd4,
        TP5     = 4'd5,
        TP6     = 4'd6,
        TP7     = 4'd7,
        TP8     = 4'd8,
        TP9     = 4'd9,
        TP10    = 4'd10,
        TP11    = 4'd11,
        TP12    = 4'd12,
        TP_GF   = 4'd13,
        TP_STBY = 4'd14
    } tp_state_t;

    // Bit n-1 is set only in state TPn; every other encoding decodes to zero.
    function automatic logic [TP_COUNT-1:0] tp_decode(input tp_state_t s);
        logic [TP_COUNT-1:0] hot;
        hot = '0;
        for (int i = 0; i < TP_COUNT; i++) begin
            hot[i] = (4'(s) == 4'(i + 1));
        end
        return hot;
    endfunction

endpackage

// File: rtl/time_pulse_generator.sv
// Time-pulse sequencer: steps TP_GF, TP1..TP12 on each ct strobe, with halt,
// standby and monitor single-step control at memory-cycle boundaries.
//
// state   | meaning
// --------+---------------------------------------------------------------
// TP_ZERO | idle between memory cycles; stop/stby/single-step decided here
// TP_GF   | one-pulse lead-in before the first time pulse of a cycle
// TP1-12  | time pulses T1..T12 of a memory cycle
// TP_STBY | standby; held while stby remains asserted
module time_pulse_generator
    import agc_tpg_pkg::*;
#(
    parameter int MCW = 12
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                ct,
    input  logic                stop,
    input  logic                stby,
    input  logic                mstp,
    input  logic                mstep,
    output logic [TP_COUNT-1:0] tp,
    output logic                tpzero,
    output logic                stbyst,
    output logic                mct,
    output logic [MCW-1:0]      mcount
);

    tp_state_t state;
    tp_state_t state_next;
    logic      step_pending;
    logic      step_granted;
    logic      leave_zero;
    logic      end_of_cycle;

    assign end_of_cycle = ct && (state == TP12);

    always_comb begin
        state_next   = state;
        leave_zero   = 1'b0;
        step_granted = step_pending | (mstep & mstp);
        if (ct) begin
            case (state)
                TP_ZERO: begin
                    if (stby) begin
                        state_next = TP_STBY;
                    end else if (!stop && (!mstp || step_granted)) begin
                        state_next = TP_GF;
                        leave_zero = 1'b1;
                    end
                end
                TP_GF: state_next = TP1;
                TP1, TP2, TP3, TP4, TP5, TP6, TP7, TP8, TP9, TP10, TP11:
                    state_next = tp_state_t'(state + 4'd1);
                TP12: state_next = (stop || stby || mstp) ? TP_ZERO : TP1;
                TP_STBY: begin
                    if (!stby) begin
                        state_next = TP_ZERO;
                    end
                end
                // Encoding 15 is unreachable; fall back to idle on the next strobe.
                default: state_next = TP_ZERO;
            endcase
        end
    end

    // Outputs are decoded from state_next so they line up with the state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= TP_ZERO;
            tp           <= '0;
            tpzero       <= 1'b1;
            stbyst       <= 1'b0;
            mct          <= 1'b0;
            mcount       <= '0;
            step_pending <= 1'b0;
        end else begin
            state  <= state_next;
            tp     <= tp_decode(state_next);
            tpzero <= (state_next == TP_ZERO);
            stbyst <= (state_next == TP_STBY);
            mct    <= end_of_cycle;
            if (end_of_cycle) begin
                mcount <= mcount + MCW'(1);
            end
            if (leave_zero) begin
                step_pending <= 1'b0;
            end else if (mstep && mstp) begin
                step_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_pulse_generator.sv
// Self-checking bench for time_pulse_generator: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_time_pulse_generator;

    localparam int MCW    = 12;
    localparam int M_ZERO = 0;
    localparam int M_GF   = 1;
    localparam int M_RUN  = 2;
    localparam int M_STBY = 3;

    logic           clock = 1'b0;
    logic           rst, ct, stop, stby, mstp, mstep;
    logic [11:0]    tp;
    logic           tpzero, stbyst, mct;
    logic [MCW-1:0] mcount;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus current pulse number within a memory cycle.
    int m_mode   = M_ZERO;
    int m_k      = 0;
    int m_mcount = 0;
    bit m_pend   = 1'b0;
    bit m_mct    = 1'b0;

    always #5 clock = ~clock;

    time_pulse_generator #(.MCW(MCW)) dut (
        .clock  (clock),
        .rst    (rst),
        .ct     (ct),
        .stop   (stop),
        .stby   (stby),
        .mstp   (mstp),
        .mstep  (mstep),
        .tp     (tp),
        .tpzero (tpzero),
        .stbyst (stbyst),
        .mct    (mct),
        .mcount (mcount)
    );

    function automatic logic [11:0] exp_tp();
        logic [11:0] one;
        one = 12'(1);
        return (m_mode == M_RUN) ? (one << (m_k - 1)) : 12'h000;
    endfunction

    task automatic model_update();
        bit grant;
        bit leaving;
        if (rst) begin
            m_mode = M_ZERO; m_k = 0; m_pend = 0; m_mcount = 0; m_mct = 0;
            return;
        end
        grant   = m_pend || (mstep && mstp);
        leaving = 0;
        m_mct   = 0;
        if (ct) begin
            case (m_mode)
                M_ZERO: begin
                    if (stby) m_mode = M_STBY;
                    else if (stop) ;
                    else if (mstp && !grant) ;
                    else begin m_mode = M_GF; leaving = 1; end
                end
                M_GF: begin m_mode = M_RUN; m_k = 1; end
                M_RUN: begin
                    if (m_k < 12) m_k++;
                    else begin
                        m_mct    = 1;
                        m_mcount = (m_mcount + 1) % (1 << MCW);
                        if (stop || stby || mstp) m_mode = M_ZERO;
                        else m_k = 1;
                    end
                end
                M_STBY: if (!stby) m_mode = M_ZERO;
                default: ;
            endcase
        end
        if (leaving) m_pend = 0;
        else if (mstep && mstp) m_pend = 1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ct = 0; stop = 0; stby = 0; mstp = 0; mstep = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; ct = 1; mstep = 1; mstp = 1;
        tick();
        checks++; if (tp !== 12'h000) begin errors++; $display("FAIL reset_tp: got %h expected 000", tp); end
        checks++; if (tpzero !== 1'b1) begin errors++; $display("FAIL reset_tpzero: got %b expected 1", tpzero); end
        checks++; if (stbyst !== 1'b0) begin errors++; $display("FAIL reset_stbyst: got %b expected 0", stbyst); end
        checks++; if (mct !== 1'b0) begin errors++; $display("FAIL reset_mct: got %b expected 0", mct); end
        checks++; if (mcount !== '0) begin errors++; $display("FAIL reset_mcount: got %0d expected 0", mcount); end
        idle_inputs();
    endtask

    task automatic test_basic_cycle();
        logic [11:0] one;
        int mct_seen;
        one = 12'(1);
        mct_seen = 0;
        do_reset();
        repeat (3) tick();
        ct = 1; tick(); ct = 0;
        checks++; if (tpzero !== 1'b0 || tp !== 12'h000) begin errors++; $display("FAIL basic_gf: got tpzero=%b tp=%h expected 0/000", tpzero, tp); end
        for (int i = 0; i < 12; i++) begin
            repeat (3) begin tick(); if (mct) mct_seen++; end
            ct = 1; tick(); ct = 0;
            if (mct) mct_seen++;
            checks++; if (tp !== (one << i)) begin errors++; $display("FAIL basic_tp%0d: got %h expected %h", i + 1, tp, one << i); end
        end
        checks++; if (mct_seen != 0) begin errors++; $display("FAIL basic_early_mct: got %0d expected 0", mct_seen); end
        repeat (3) tick();
        stop = 1; ct = 1; tick(); ct = 0;
        checks++; if (mct !== 1'b1) begin errors++; $display("FAIL basic_mct: got %b expected 1", mct); end
        checks++; if (mcount !== MCW'(1)) begin errors++; $display("FAIL basic_mcount: got %0d expected 1", mcount); end
        checks++; if (tpzero !== 1'b1) begin errors++; $display("FAIL basic_zero: got %b expected 1", tpzero); end
        tick();
        checks++; if (mct !== 1'b0) begin errors++; $display("FAIL basic_mct_width: got %b expected 0", mct); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        int mct_seen;
        int bad_hot;
        int budget;
        mct_seen = 0; bad_hot = 0; budget = 0;
        do_reset();
        ct = 1;
        while (mct_seen < 4097 && budget < 60000) begin
            tick();
            budget++;
            if (mct) mct_seen++;
            if ($countones(tp) > 1) bad_hot++;
        end
        checks++; if (mct_seen != 4097) begin errors++; $display("FAIL wrap_mct_count: got %0d expected 4097 (budget expired?)", mct_seen); end
        checks++; if (mcount !== MCW'(1)) begin errors++; $display("FAIL wrap_mcount: got %0d expected 1", mcount); end
        checks++; if (bad_hot != 0) begin errors++; $display("FAIL wrap_onehot: got %0d multi-hot cycles expected 0", bad_hot); end
        idle_inputs();
    endtask

    task automatic test_stop();
        do_reset();
        ct = 1;
        repeat (6) tick();
        checks++; if (tp !== 12'h010) begin errors++; $display("FAIL stop_tp5: got %h expected 010", tp); end
        stop = 1;
        repeat (7) tick();
        checks++; if (tp !== 12'h800) begin errors++; $display("FAIL stop_tp12: got %h expected 800", tp); end
        tick();
        checks++; if (tpzero !== 1'b1 || mct !== 1'b1) begin errors++; $display("FAIL stop_zero: got tpzero=%b mct=%b expected 1/1", tpzero, mct); end
        repeat (3) tick();
        checks++; if (tpzero !== 1'b1) begin errors++; $display("FAIL stop_hold: got %b expected 1", tpzero); end
        stop = 0;
        tick();
        checks++; if (tpzero !== 1'b0 || tp !== 12'h000 || stbyst !== 1'b0) begin errors++; $display("FAIL stop_release: got tpzero=%b tp=%h expected 0/000", tpzero, tp); end
        idle_inputs();
    endtask

    task automatic test_single_step();
        int mct_seen;
        int tp_cycles;
        mct_seen = 0; tp_cycles = 0;
        do_reset();
        stop = 1; mstep = 1; tick(); mstep = 0; tick();
        stop = 0; mstp = 1; ct = 1;
        repeat (5) tick();
        checks++; if (tpzero !== 1'b1) begin errors++; $display("FAIL step_ignored: got tpzero=%b expected 1", tpzero); end
        ct = 0; mstep = 1; tick(); mstep = 0;
        ct = 1;
        repeat (30) begin
            tick();
            if (mct) mct_seen++;
            if (tp !== 12'h000) tp_cycles++;
        end
        checks++; if (mct_seen != 1) begin errors++; $display("FAIL step_mct: got %0d expected 1", mct_seen); end
        checks++; if (tp_cycles != 12) begin errors++; $display("FAIL step_pulses: got %0d expected 12", tp_cycles); end
        checks++; if (tpzero !== 1'b1) begin errors++; $display("FAIL step_return: got %b expected 1", tpzero); end
        idle_inputs();
    endtask

    task automatic test_standby();
        do_reset();
        stby = 1; tick();
        checks++; if (stbyst !== 1'b0 || tpzero !== 1'b1) begin errors++; $display("FAIL stby_no_ct: got stbyst=%b tpzero=%b expected 0/1", stbyst, tpzero); end
        ct = 1; tick();
        checks++; if (stbyst !== 1'b1 || tpzero !== 1'b0) begin errors++; $display("FAIL stby_enter: got stbyst=%b tpzero=%b expected 1/0", stbyst, tpzero); end
        repeat (3) tick();
        checks++; if (stbyst !== 1'b1) begin errors++; $display("FAIL stby_hold: got %b expected 1", stbyst); end
        stby = 0; ct = 0; tick();
        checks++; if (stbyst !== 1'b1) begin errors++; $display("FAIL stby_wait_ct: got %b expected 1", stbyst); end
        ct = 1; tick();
        checks++; if (stbyst !== 1'b0 || tpzero !== 1'b1) begin errors++; $display("FAIL stby_exit: got stbyst=%b tpzero=%b expected 0/1", stbyst, tpzero); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ct = 1;
        repeat (14) tick();
        checks++; if (mct !== 1'b1 || mcount !== MCW'(1) || tp !== 12'h001) begin errors++; $display("FAIL rmid_cycle: got mct=%b mcount=%0d tp=%h expected 1/1/001", mct, mcount, tp); end
        repeat (6) tick();
        checks++; if (tp !== 12'h040) begin errors++; $display("FAIL rmid_tp7: got %h expected 040", tp); end
        rst = 1; mstep = 1; mstp = 1; tick();
        checks++; if (tp !== 12'h000 || tpzero !== 1'b1 || mcount !== '0 || mct !== 1'b0) begin errors++; $display("FAIL rmid_reset: got tp=%h tpzero=%b mcount=%0d mct=%b expected 000/1/0/0", tp, tpzero, mcount, mct); end
        idle_inputs();
        tick();
        checks++; if (mct !== 1'b0 || tpzero !== 1'b1) begin errors++; $display("FAIL rmid_after: got mct=%b tpzero=%b expected 0/1", mct, tpzero); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            ct    = ($urandom_range(0, 1) == 1);
            stop  = ($urandom_range(0, 3) == 0);
            stby  = ($urandom_range(0, 7) == 0);
            mstp  = ($urandom_range(0, 3) == 0);
            mstep = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (tp !== exp_tp()) begin errors++; $display("FAIL rand_tp[%0d]: got %h expected %h", n, tp, exp_tp()); end
            checks++; if (tpzero !== (m_mode == M_ZERO)) begin errors++; $display("FAIL rand_tpzero[%0d]: got %b expected %b", n, tpzero, m_mode == M_ZERO); end
            checks++; if (stbyst !== (m_mode == M_STBY)) begin errors++; $display("FAIL rand_stbyst[%0d]: got %b expected %b", n, stbyst, m_mode == M_STBY); end
            checks++; if (mct !== m_mct) begin errors++; $display("FAIL rand_mct[%0d]: got %b expected %b", n, mct, m_mct); end
            checks++; if (mcount !== MCW'(m_mcount)) begin errors++; $display("FAIL rand_mcount[%0d]: got %0d expected %0d", n, mcount, m_mcount); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_cycle();
        test_stop();
        test_single_step();
        test_standby();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
